dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Single-port data memory target that sits on the LSU-side mem_* interface and services one outstanding request at a time. Read, write and cache-maintenance requests are accepted with a ready/valid handshake; each is answered with a single-cycle ack after a configurable wait. Out-of-window addresses return a bus error. Intended as the TCM behind the core's LSU and as the bench memory model for LSU verification.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
MEM_WORDS, 1024, depth in 32-bit words; power of two
ADDR_W, 10, log2(MEM_WORDS)
WAIT_STATES, 0, extra cycles between accept and ack (0..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
mem_addr_i  in  32  request byte address; bits [1:0] ignored
mem_data_wr_i  in  32  write data, lane-aligned
mem_rd_i  in  1  read request
mem_wr_i  in  4  byte write enables; nonzero = write request
mem_cacheable_i  in  1  ignored (accepted for interface completeness)
mem_req_tag_i  in  11  request tag
mem_invalidate_i  in  1  invalidate maintenance request
mem_writeback_i  in  1  writeback maintenance request
mem_flush_i  in  1  flush maintenance request
mem_accept_o  out  1  request accepted this cycle
mem_ack_o  out  1  response valid, one-cycle pulse
mem_error_o  out  1  response is a bus error; valid with ack
mem_data_rd_o  out  32  read data; valid with ack
mem_resp_tag_o  out  11  tag of the responding request
mem_load_fault_o  out  1  page fault on load; tied 0
mem_store_fault_o  out  1  page fault on store; tied 0

Behaviour:
- Reset: state IDLE, accept_o=1, ack_o=0, error_o=0, data_rd_o=0, resp_tag_o=0, wait counter 0. RAM contents are not reset.
- req_w = rd_i | (|wr_i) | invalidate_i | writeback_i | flush_i. The request is taken when req_w & accept_o.
- accept_o = (state==IDLE) | (state==RESP).
- States:
  - IDLE: on take with WAIT_STATES=0, go to RESP; with WAIT_STATES>0, load the counter with WAIT_STATES and go to WAIT.
  - WAIT: decrement the counter; go to RESP when the counter reaches 1.
  - RESP: assert ack_o for exactly this cycle. A request taken in RESP is treated exactly as one taken in IDLE (back-to-back); with no take, return to IDLE.
- Latency: ack_o rises 1+WAIT_STATES cycles after the accept cycle. Throughput is one request per 1+WAIT_STATES cycles.
- On take, register the tag, type, in-range flag, word index and byte enables.
- in_range = (addr_i >= BASE_ADDR) && (addr_i - BASE_ADDR < 4*MEM_WORDS), computed in 33-bit arithmetic so the upper bound cannot wrap. Word index = (addr_i - BASE_ADDR)[ADDR_W+1:2].
- Write, in range: RAM is updated on the take edge, per-byte by wr_i. At ack, error_o=0 and data_rd_o=0.
- Read, in range: RAM is read so that data_rd_o at ack reflects all writes taken earlier.
- Out of range (read or write): no RAM update. At ack, error_o=1 and data_rd_o=0.
- Maintenance (invalidate, writeback or flush): no RAM access. At ack, error_o=0 and data_rd_o=0.
- Illegal combinations raise error_o=1 at ack with no RAM update:
  - rd_i together with nonzero wr_i;
  - more than one maintenance bit;
  - a maintenance bit together with rd or wr.
- When ack_o=0: error_o=0, data_rd_o=0, resp_tag_o holds its last value.
- Reset mid-operation: any pending ack is dropped; state returns to IDLE. A write whose take edge has completed has already modified RAM.
- Requests presented while accept_o=0 are ignored; the initiator must hold them.

Test Plan:
- Write 32'hDEADBEEF to BASE+0x10 (wr=4'hF, tag 5), then read BASE+0x10 (tag 6) → acks with tags 5 then 6, read data 32'hDEADBEEF, error 0.
- Byte write 8'hA5 with wr=4'b0100, data 32'h00A50000, over 32'h11223344 → readback 32'h11A53344.
- Read at BASE+4*MEM_WORDS and at BASE-4 (BASE≠0) → ack with error=1, data 0; an in-range word at the same index is unchanged.
- WAIT_STATES=3: accept at cycle t → ack at t+4 only; accept_o=0 for cycles t+1..t+3; a request held during those cycles is taken at t+4.
- Back-to-back: new read presented during the RESP cycle → accept_o=1 that cycle; next ack 1+WAIT_STATES cycles later; no bubble.
- Flush request → ack, error 0, data 0, RAM unchanged. rd=1 with wr=4'h1 → ack with error=1, no write. Assert rst_i in WAIT → ack never appears, accept_o=1 after reset.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Single-port data memory target for the LSU-side mem_* interface. It services
// one outstanding request at a time. Each accepted request (read, write or
// cache maintenance) gets exactly one single-cycle ack, WAIT_STATES cycles
// after the cycle that follows the accept. Addresses outside the window
// [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) return a bus error.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mem_addr_i            request byte address (bits [1:0] ignored)
//   mem_data_wr_i         lane-aligned write data
//   mem_rd_i              read request
//   mem_wr_i              byte write enables (nonzero = write request)
//   mem_cacheable_i       ignored
//   mem_req_tag_i         request tag, echoed on mem_resp_tag_o
//   mem_invalidate_i      invalidate maintenance request
//   mem_writeback_i       writeback maintenance request
//   mem_flush_i           flush maintenance request
//   mem_accept_o          request taken when asserted together with a request
//   mem_ack_o             one-cycle response strobe
//   mem_error_o           bus error, valid with ack
//   mem_data_rd_o         read data, valid with ack (0 otherwise)
//   mem_resp_tag_o        tag of the responding request; holds between acks
//   mem_load_fault_o      tied 0
//   mem_store_fault_o     tied 0
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_wr_i,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic        mem_cacheable_i,
    input  logic [10:0] mem_req_tag_i,
    input  logic        mem_invalidate_i,
    input  logic        mem_writeback_i,
    input  logic        mem_flush_i,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic        mem_error_o,
    output logic [31:0] mem_data_rd_o,
    output logic [10:0] mem_resp_tag_o,
    output logic        mem_load_fault_o,
    output logic        mem_store_fault_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [32:0] WINDOW_BYTES = 33'(4 * MEM_WORDS);
    localparam logic [3:0]  WAIT_LOAD    = 4'(WAIT_STATES);

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic [10:0] tag_q;        // tag of the request in flight / being acked
    logic [10:0] last_tag_q;   // tag of the most recent completed ack
    logic        rd_ok_q;      // in-flight request is a legal in-range read
    logic        err_q;        // in-flight request answers with a bus error

    logic [31:0] ram_rdata;

    // The cacheable hint has no meaning for a tightly coupled memory.
    logic unused_cacheable;
    assign unused_cacheable = mem_cacheable_i;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic        req_w;
    logic        take_w;
    logic        any_wr_w;
    logic        any_maint_w;
    logic [1:0]  maint_cnt_w;
    logic        illegal_w;
    logic [32:0] addr_ext_w;
    logic [32:0] offset_w;
    logic        in_range_w;
    logic [ADDR_W-1:0] word_idx_w;
    logic        ram_wr_en_w;
    logic        ram_rd_en_w;
    logic        err_w;

    assign any_wr_w    = |mem_wr_i;
    assign any_maint_w = mem_invalidate_i | mem_writeback_i | mem_flush_i;
    assign maint_cnt_w = 2'(mem_invalidate_i) + 2'(mem_writeback_i) + 2'(mem_flush_i);

    assign req_w        = mem_rd_i | any_wr_w | any_maint_w;
    assign mem_accept_o = (state_q == ST_IDLE) || (state_q == ST_RESP);
    // A request presented while reset is held must not reach the RAM.
    assign take_w       = req_w & mem_accept_o & ~rst_i;

    assign illegal_w = (mem_rd_i & any_wr_w)
                     | (maint_cnt_w > 2'd1)
                     | (any_maint_w & (mem_rd_i | any_wr_w));

    // 33-bit arithmetic: an address below BASE_ADDR yields a huge offset and
    // the upper bound compare cannot wrap near the top of the address space.
    assign addr_ext_w = {1'b0, mem_addr_i};
    assign offset_w   = addr_ext_w - {1'b0, BASE_ADDR};
    assign in_range_w = (addr_ext_w >= {1'b0, BASE_ADDR}) && (offset_w < WINDOW_BYTES);
    assign word_idx_w = offset_w[ADDR_W+1:2];

    // illegal_w already excludes mixes of read, write and maintenance.
    assign ram_wr_en_w = take_w & any_wr_w & ~illegal_w & in_range_w;
    assign ram_rd_en_w = take_w & mem_rd_i & ~illegal_w & in_range_w;
    assign err_w       = illegal_w | ((mem_rd_i | any_wr_w) & ~in_range_w);

    // -----------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane so each lane maps onto a plain
    // single-port block RAM with its own write enable. Read data is
    // registered on the take edge and held until the ack, so wait states
    // need no extra read cycle. Reads and writes never share a take edge.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_rdata_q;

            always_ff @(posedge clk_i) begin
                if (ram_wr_en_w && mem_wr_i[gi]) begin
                    lane_mem[word_idx_w] <= mem_data_wr_i[gi*8 +: 8];
                end
                if (ram_rd_en_w) begin
                    lane_rdata_q <= lane_mem[word_idx_w];
                end
            end

            assign ram_rdata[gi*8 +: 8] = lane_rdata_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            tag_q      <= 11'd0;
            last_tag_q <= 11'd0;
            rd_ok_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == ST_RESP) begin
                last_tag_q <= tag_q;
            end

            case (state_q)
                ST_IDLE, ST_RESP: begin
                    // A take in RESP is handled exactly like one in IDLE,
                    // which gives back-to-back throughput without a bubble.
                    if (take_w) begin
                        tag_q   <= mem_req_tag_i;
                        rd_ok_q <= ram_rd_en_w;
                        err_q   <= err_w;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            wait_cnt_q <= WAIT_LOAD;
                            state_q    <= ST_WAIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Response outputs (decoded from registered state only)
    // -----------------------------------------------------------------------
    assign mem_ack_o         = (state_q == ST_RESP);
    assign mem_error_o       = mem_ack_o & err_q;
    assign mem_data_rd_o     = (mem_ack_o && rd_ok_q) ? ram_rdata : 32'd0;
    assign mem_resp_tag_o    = mem_ack_o ? tag_q : last_tag_q;
    assign mem_load_fault_o  = 1'b0;
    assign mem_store_fault_o = 1'b0;

endmodule
